// File: rtl/segment_display_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : segment_display_scheduler_pkg
// Purpose  : Shared constants and types for the segment display scheduler.
//            Owner encoding seen on the Owner port, the scan phase meaning,
//            and the arbiter state type (encoded identically to Owner so the
//            state register can drive the port directly).
// Revision : 1.0 - initial release
// ============================================================================
package segment_display_scheduler_pkg;

   localparam logic [1:0] OWNER_IDLE = 2'd0;
   localparam logic [1:0] OWNER_A    = 2'd1;
   localparam logic [1:0] OWNER_B    = 2'd2;

   // Phase value during which the high digit of each pair is shown
   localparam logic PHASE_HIGH = 1'b1;

   typedef enum logic [1:0] {
      ARB_IDLE  = OWNER_IDLE,
      ARB_OWN_A = OWNER_A,
      ARB_OWN_B = OWNER_B
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/BCD7Segment.sv
`default_nettype none
// ============================================================================
// Module   : BCD7Segment
// Purpose  : Combinational BCD to 7-segment decoder, active-high segments.
// Ports    : Bcd [3:0] in  - BCD digit 0..9
//            Seg [6:0] out - {a,b,c,d,e,f,g}; non-BCD codes blank
// Revision : 1.0 - initial release
// ============================================================================
module BCD7Segment (
   input  logic [3:0] Bcd,
   output logic [6:0] Seg
);

   always_comb begin
      Seg = 7'b000_0000;
      case (Bcd)
         4'd0: Seg = 7'b111_1110;
         4'd1: Seg = 7'b011_0000;
         4'd2: Seg = 7'b110_1101;
         4'd3: Seg = 7'b111_1001;
         4'd4: Seg = 7'b011_0011;
         4'd5: Seg = 7'b101_1011;
         4'd6: Seg = 7'b101_1111;
         4'd7: Seg = 7'b111_0000;
         4'd8: Seg = 7'b111_1111;
         4'd9: Seg = 7'b111_1011;
         default: Seg = 7'b000_0000;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/segment_display_scheduler_scan_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : scan_prescaler
// Purpose  : Divides CLK into scan phases of SCAN_DIV cycles and flags the
//            frame boundary (the tick on which Phase returns to 0).
// Ports    : CLK      in  - system clock
//            RST_N    in  - synchronous active-low reset
//            Tick     out - last cycle of the current scan phase
//            Phase    out - registered scan phase, 1 = high digit
//            FrameEnd out - Tick while Phase is high
// Revision : 1.0 - initial release
// ============================================================================
module scan_prescaler
   import segment_display_scheduler_pkg::*;
#(
   parameter int SCAN_DIV = 50000
) (
   input  logic CLK,
   input  logic RST_N,
   output logic Tick,
   output logic Phase,
   output logic FrameEnd
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] cnt;
   logic             phase_q;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         cnt     <= '0;
         phase_q <= 1'b0;
      end else if (Tick) begin
         cnt     <= '0;
         phase_q <= ~phase_q;
      end else begin
         cnt     <= cnt + CNT_W'(1);
      end
   end

   assign Tick     = (cnt == CNT_MAX);
   assign Phase    = phase_q;
   assign FrameEnd = Tick && (phase_q == PHASE_HIGH);

endmodule
`default_nettype wire

// File: rtl/segment_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : segment_display_scheduler
// Purpose  : Scan controller and frame-aligned arbiter sharing a two-pair
//            7-segment display between two 16-bit BCD requesters. Ownership
//            and the displayed value only change at frame boundaries, and an
//            owner keeps the display for HOLD_FRAMES frames while contested.
// Ports    : CLK, RST_N           - clock, synchronous active-low reset
//            ReqA/DataA, ReqB/DataB - requests with held BCD values
//            AckA, AckB           - one-cycle pulse when a value is latched
//            Owner                - 0 idle, 1 A, 2 B
//            Phase                - scan phase, 1 = high digit of each pair
//            Segment7_1/Segment7_0 - {decoded digit, Phase as DP}
// Revision : 1.0 - initial release
// ============================================================================
module segment_display_scheduler
   import segment_display_scheduler_pkg::*;
#(
   parameter int SCAN_DIV    = 50000,
   parameter int HOLD_FRAMES = 4
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        ReqA,
   input  logic [15:0] DataA,
   input  logic        ReqB,
   input  logic [15:0] DataB,
   output logic        AckA,
   output logic        AckB,
   output logic [1:0]  Owner,
   output logic        Phase,
   output logic [7:0]  Segment7_0,
   output logic [7:0]  Segment7_1
);

   localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES);

   logic tick;
   logic phase;
   logic frame_end;
   logic frame_boundary;

   scan_prescaler #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scan_prescaler (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .Tick     (tick),
      .Phase    (phase),
      .FrameEnd (frame_end)
   );

   // FrameEnd already implies Tick; qualifying with both keeps the boundary
   // explicitly tied to the end of a scan phase.
   assign frame_boundary = tick && frame_end;

   arb_state_t        state,        state_nxt;
   logic [HOLD_W-1:0] hold_cnt,     hold_nxt;
   logic              last_owner_b, last_owner_b_nxt;
   logic [15:0]       latch,        latch_nxt;
   logic              ack_a_nxt,    ack_b_nxt;
   logic [HOLD_W-1:0] hold_inc;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state        <= ARB_IDLE;
         hold_cnt     <= '0;
         last_owner_b <= 1'b1;
         latch        <= 16'h0000;
         AckA         <= 1'b0;
         AckB         <= 1'b0;
      end else begin
         state        <= state_nxt;
         hold_cnt     <= hold_nxt;
         last_owner_b <= last_owner_b_nxt;
         latch        <= latch_nxt;
         AckA         <= ack_a_nxt;
         AckB         <= ack_b_nxt;
      end
   end

   always_comb begin
      state_nxt        = state;
      hold_nxt         = hold_cnt;
      last_owner_b_nxt = last_owner_b;
      latch_nxt        = latch;
      ack_a_nxt        = 1'b0;
      ack_b_nxt        = 1'b0;
      hold_inc         = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HOLD_W'(1);

      if (frame_boundary) begin
         case (state)
            ARB_OWN_A: begin
               if (ReqA && ((hold_cnt < HOLD_MAX) || !ReqB)) begin
                  state_nxt = ARB_OWN_A;
                  hold_nxt  = hold_inc;
               end else if (ReqB) begin
                  state_nxt = ARB_OWN_B;
                  hold_nxt  = HOLD_W'(1);
               end else begin
                  state_nxt = ARB_IDLE;
                  hold_nxt  = '0;
               end
            end
            ARB_OWN_B: begin
               if (ReqB && ((hold_cnt < HOLD_MAX) || !ReqA)) begin
                  state_nxt = ARB_OWN_B;
                  hold_nxt  = hold_inc;
               end else if (ReqA) begin
                  state_nxt = ARB_OWN_A;
                  hold_nxt  = HOLD_W'(1);
               end else begin
                  state_nxt = ARB_IDLE;
                  hold_nxt  = '0;
               end
            end
            default: begin
               // Tie goes to whichever source did not own the display last
               if (ReqA && ReqB) begin
                  state_nxt = last_owner_b ? ARB_OWN_A : ARB_OWN_B;
                  hold_nxt  = HOLD_W'(1);
               end else if (ReqA) begin
                  state_nxt = ARB_OWN_A;
                  hold_nxt  = HOLD_W'(1);
               end else if (ReqB) begin
                  state_nxt = ARB_OWN_B;
                  hold_nxt  = HOLD_W'(1);
               end else begin
                  state_nxt = ARB_IDLE;
               end
            end
         endcase

         // Every boundary that lands in an owned state re-latches and acks,
         // whether it is a fresh grant or a continuation.
         case (state_nxt)
            ARB_OWN_A: begin
               latch_nxt        = DataA;
               ack_a_nxt        = 1'b1;
               last_owner_b_nxt = 1'b0;
            end
            ARB_OWN_B: begin
               latch_nxt        = DataB;
               ack_b_nxt        = 1'b1;
               last_owner_b_nxt = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign Owner = state;
   assign Phase = phase;

   logic [3:0] digit_hi;
   logic [3:0] digit_lo;
   logic [6:0] seg_hi;
   logic [6:0] seg_lo;

   assign digit_hi = (phase == PHASE_HIGH) ? latch[15:12] : latch[11:8];
   assign digit_lo = (phase == PHASE_HIGH) ? latch[7:4]   : latch[3:0];

   BCD7Segment u_dec_hi (
      .Bcd (digit_hi),
      .Seg (seg_hi)
   );

   BCD7Segment u_dec_lo (
      .Bcd (digit_lo),
      .Seg (seg_lo)
   );

   assign Segment7_1 = {seg_hi, phase};
   assign Segment7_0 = {seg_lo, phase};

endmodule
`default_nettype wire

// File: tb/tb_segment_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_segment_display_scheduler
// Purpose  : Self-checking bench for segment_display_scheduler with
//            SCAN_DIV=4, HOLD_FRAMES=2. A reference model counts edges since
//            reset, arbitrates every eighth edge and queues expected acks; a
//            monitor pops the queue whenever an ack is presented.
// Revision : 1.0 - initial release
// ============================================================================
module tb_segment_display_scheduler;

   localparam int SD    = 4;
   localparam int HF    = 2;
   localparam int FRAME = 2 * SD;
   localparam int NCYC  = 4000;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        ReqA = 1'b0;
   logic        ReqB = 1'b0;
   logic [15:0] DataA = 16'h0000;
   logic [15:0] DataB = 16'h0000;
   logic        AckA;
   logic        AckB;
   logic [1:0]  Owner;
   logic        Phase;
   logic [7:0]  Segment7_0;
   logic [7:0]  Segment7_1;

   segment_display_scheduler #(
      .SCAN_DIV    (SD),
      .HOLD_FRAMES (HF)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .ReqA       (ReqA),
      .DataA      (DataA),
      .ReqB       (ReqB),
      .DataB      (DataB),
      .AckA       (AckA),
      .AckB       (AckB),
      .Owner      (Owner),
      .Phase      (Phase),
      .Segment7_0 (Segment7_0),
      .Segment7_1 (Segment7_1)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        ack_a;
      logic        ack_b;
      logic [1:0]  owner;
      logic [15:0] data;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int failures = 0;

   // Reference model state
   int          n = 0;        // rising edges since reset release
   int          m_owner = 0;  // 0 idle, 1 A, 2 B
   int          m_hold = 0;
   int          m_last = 2;
   logic [15:0] m_latch = 16'h0000;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] t [10];
      t = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
      return (d < 4'd10) ? t[d] : 7'h00;
   endfunction

   // Pair position hi=1 is the thousands/hundreds pair; ph=1 selects the
   // higher digit of that pair.
   function automatic logic [7:0] exp_seg(input logic [15:0] v, input logic ph, input logic hi);
      int sh;
      sh = (hi ? 8 : 0) + (ph ? 4 : 0);
      return {seg7(4'((v >> sh) & 16'h000F)), ph};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
      end
   endtask

   function automatic logic [15:0] rand_bcd();
      logic [15:0] v;
      v = 16'h0000;
      for (int i = 0; i < 4; i++) v = (v << 4) | 16'($urandom_range(0, 9));
      return v;
   endfunction

   // Model one rising edge using the inputs currently driven
   task automatic model_step();
      int  x, o, nw;
      bit  rx, ro;
      exp_t e;
      if (!RST_N) begin
         n = 0; m_owner = 0; m_hold = 0; m_last = 2; m_latch = 16'h0000;
         return;
      end
      n++;
      if (n % FRAME != 0) return;
      if (m_owner != 0) begin
         x  = m_owner;
         o  = 3 - x;
         rx = (x == 1) ? ReqA : ReqB;
         ro = (o == 1) ? ReqA : ReqB;
         if (rx && (m_hold < HF || !ro)) begin
            nw = x;
            m_hold = (m_hold + 1 > HF) ? HF : m_hold + 1;
         end else if (ro) begin
            nw = o; m_hold = 1;
         end else begin
            nw = 0;
         end
      end else begin
         if (ReqA && ReqB) nw = (m_last == 1) ? 2 : 1;
         else if (ReqA)    nw = 1;
         else if (ReqB)    nw = 2;
         else              nw = 0;
         if (nw != 0) m_hold = 1;
      end
      m_owner = nw;
      if (nw != 0) begin
         m_latch = (nw == 1) ? DataA : DataB;
         m_last  = nw;
         e.ack_a = (nw == 1);
         e.ack_b = (nw == 2);
         e.owner = 2'(nw);
         e.data  = m_latch;
         sb.push_back(e);
      end
   endtask

   // Scoreboard monitor: every presented ack must match the queued grant
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (AckA || AckB) begin
            if (sb.size() == 0) begin
               chk("unexpected_ack", {30'd0, AckA, AckB}, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("ack_pair", {30'd0, AckA, AckB}, {30'd0, e.ack_a, e.ack_b});
               chk("ack_owner", 32'(Owner), 32'(e.owner));
               chk("ack_seg1", 32'(Segment7_1), 32'(exp_seg(e.data, Phase, 1'b1)));
               chk("ack_seg0", 32'(Segment7_0), 32'(exp_seg(e.data, Phase, 1'b0)));
            end
         end else if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("missing_ack", {30'd0, AckA, AckB}, {30'd0, e.ack_a, e.ack_b});
         end
      end
   end

   task automatic drive(input int c);
      if (c < 3) begin
         RST_N = 1'b0; ReqA = 1'b1; DataA = 16'h1234; ReqB = 1'b0;
      end else if (c < 100) begin
         RST_N = 1'b1;
         if (c == 13) DataA = 16'h9999;                 // mid-frame data change
         if (c == 20) begin ReqB = 1'b1; DataB = 16'h5678; end
         if (c == 60) ReqA = 1'b0;
         if (c == 72) ReqB = 1'b0;
         if (c == 80) begin ReqB = 1'b1; DataB = 16'h4321; end
         if (c == 93) RST_N = 1'b0;                     // mid-frame reset
      end else begin
         RST_N = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 15) == 0) ReqA = ~ReqA;
         if ($urandom_range(0, 15) == 0) ReqB = ~ReqB;
         if ($urandom_range(0, 9) == 0)  DataA = rand_bcd();
         if ($urandom_range(0, 9) == 0)  DataB = rand_bcd();
      end
   endtask

   initial begin
      logic ph;
      for (int c = 0; c < NCYC; c++) begin
         drive(c);
         @(posedge CLK);
         model_step();
         @(negedge CLK);
         ph = ((n / SD) % 2) == 1;
         chk("phase", 32'(Phase), 32'(ph));
         chk("owner", 32'(Owner), 32'(m_owner));
         chk("seg1", 32'(Segment7_1), 32'(exp_seg(m_latch, ph, 1'b1)));
         chk("seg0", 32'(Segment7_0), 32'(exp_seg(m_latch, ph, 1'b0)));
      end
      @(negedge CLK);
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/segment_display_scheduler.md
# segment_display_scheduler

Scan controller and display arbiter for the two-digit-pair 7-segment display. It replaces raw-clock digit multiplexing with a prescaled scan phase. It shares the display between two 16-bit BCD requesters using a frame-aligned request/ack handshake and a minimum hold time. Displayed data changes only at frame boundaries, so no frame ever shows a mix of two values. It sits between the datapath/timer result producers and the board segment pins.

## Interface
- SCAN_DIV, 50000, CLK cycles per scan phase (≥2)
- HOLD_FRAMES, 4, minimum consecutive frames an owner keeps the display while the other requester waits (≥1)

- CLK  in  1  system clock, rising edge
- RST_N  in  1  reset, synchronous, active-low
- ReqA  in  1  requester A wants the display; held high with DataA stable
- DataA  in  16  requester A BCD value, digits [15:12],[11:8],[7:4],[3:0]
- ReqB  in  1  requester B request
- DataB  in  16  requester B BCD value
- AckA  out  1  one-cycle pulse: DataA latched for the coming frame
- AckB  out  1  one-cycle pulse: DataB latched
- Owner  out  2  0=IDLE, 1=A, 2=B
- Phase  out  1  scan phase; 1 = high digit of each pair
- Segment7_0  out  8  [7:1] decoded tens/ones digit, [0] = Phase
- Segment7_1  out  8  [7:1] decoded thousands/hundreds digit, [0] = Phase

## Operation
- Prescaler Cnt counts 0..SCAN_DIV-1. Tick = (Cnt==SCAN_DIV-1). On a tick edge, Cnt wraps to 0 and Phase toggles.
- Frame boundary = Tick && Phase==1, the edge where Phase returns to 0. One frame = 2*SCAN_DIV cycles.
- Display mux from the Latch register:
  - Phase=1: Segment7_1 shows Latch[15:12], Segment7_0 shows Latch[7:4].
  - Phase=0: Segment7_1 shows Latch[11:8], Segment7_0 shows Latch[3:0].
- Arbiter states: IDLE, OWN_A, OWN_B. It evaluates only at frame boundaries.
- HoldCnt counts consecutive frames granted to the current owner. It is set to 1 on a new grant and increments, saturating at HOLD_FRAMES.
- OWN_X at a boundary:
  - If ReqX && (HoldCnt<HOLD_FRAMES || !ReqOther): stay in OWN_X.
  - Else if ReqOther: switch to OWN_Other.
  - Else: go to IDLE.
- IDLE at a boundary:
  - One request pending: grant it.
  - Both pending: grant the source that is not LastOwner.
  - LastOwner resets to B, so A wins the first tie.
- On every boundary where the new state is OWN_X:
  - Latch takes DataX.
  - AckX = 1 for exactly one cycle.
  - LastOwner = X.
- Entering or staying in IDLE: Latch holds, no Ack.
- Data changing mid-frame is not displayed until the next boundary. Req dropping mid-frame takes effect at the next boundary.

## Timing
- Reset values:
  - Cnt=0, Phase=0, Latch=16'h0000, state IDLE, Owner=0.
  - HoldCnt=0, LastOwner=B, AckA=AckB=0.
  - Segments show decode(0) with DP=0.
- Reset applies on the first CLK edge with RST_N=0, from any state, mid-frame included.
- Phase, Owner, Ack and Latch are registered. Segment outputs are combinational decode of Latch and Phase (no extra latency).
- After reset release, the first boundary is the SCAN_DIV*2-th edge.
- Req→Ack latency: ≤2*SCAN_DIV cycles when IDLE. Worst case while the other source is held: ≤2*SCAN_DIV*HOLD_FRAMES cycles.
- Ack coincides with the edge where Latch updates. The new value is visible the same cycle Ack is high.
- Cnt width = $clog2(SCAN_DIV); HoldCnt width = $clog2(HOLD_FRAMES+1).

## Structure
- Shared package holds:
  - owner encoding constants (OWNER_IDLE=0, OWNER_A=1, OWNER_B=2)
  - phase meaning constant (PHASE_HIGH=1)
- Sub-module scan_prescaler(CLK, RST_N, Tick, Phase, FrameEnd) holds Cnt and Phase.
- Top instantiates scan_prescaler, the arbiter/latch logic, and two existing BCD7Segment decoders.

## Test plan
All scenarios use SCAN_DIV=4, HOLD_FRAMES=2 (frame = 8 cycles).
- Reset: RST_N low 3 cycles, then high.
  - Phase rises at edge 4 and falls at edge 8.
  - Owner=0, Latch=0, no Ack.
- ReqA=1, DataA=16'h1234 from reset.
  - AckA pulses at edge 8; Owner=1.
  - Phase=1: Segment7_1→decode(1), Segment7_0→decode(3), DP=1.
  - Phase=0: decode(2), decode(4), DP=0.
- ReqA=ReqB=1, DataB=16'h5678.
  - A granted at edge 8 and keeps edge 16.
  - B granted at edge 24 with AckB; A is granted again at edge 40.
- Owner A drops ReqA, ReqB=0.
  - Owner=0 at the next boundary.
  - Display keeps 1234; no Ack pulses.
- DataA changes to 16'h9999 at edge 11 while A owns.
  - Segments still show 1234 until edge 16.
  - 9999 appears at edge 16 with AckA.
- RST_N low at edge 13, mid-frame while OWN_B.
  - Edge 14: Cnt=0, Phase=0, Owner=0, Latch=0.
  - Next boundary is 8 edges after reset release.
